// File: rtl/pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module   : pipe_addsub
// Purpose  : Segmented, pipelined add/subtract with valid/ready stream and
//            ALU status flags; one SEG_W-bit segment resolved per stage.
// Revision : 1.0
// ============================================================================
module pipe_addsub #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int NSEG = WIDTH / SEG_W;

    // Per-stage inputs: index 0 is the port side, index k+1 is stage k's register.
    logic [NSEG-1:0]  w_v_in;
    logic [NSEG-1:0]  w_load;
    logic [NSEG-1:0]  w_advance;
    logic [NSEG-1:0]  w_c_in;
    logic [NSEG-1:0]  w_z_in;
    logic [WIDTH-1:0] w_a_in [NSEG];
    logic [WIDTH-1:0] w_b_in [NSEG];
    logic [WIDTH-1:0] w_s_in [NSEG];

    logic [WIDTH-1:0] w_b_eff;
    logic             w_c0;

    // Subtraction is a + ~b + 1; op[1] selects the external carry/borrow.
    assign w_b_eff = op[0] ? ~b : b;
    assign w_c0    = op[1] ? cin : op[0];

    assign w_v_in[0] = in_valid;
    assign w_a_in[0] = a;
    assign w_b_in[0] = w_b_eff;
    assign w_s_in[0] = '0;
    assign w_c_in[0] = w_c0;
    assign w_z_in[0] = 1'b1;

    assign in_ready = w_load[0];

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        logic             r_valid;
        logic             r_carry;
        logic             r_zero;
        logic [WIDTH-1:0] r_sum;
        logic [WIDTH-1:0] w_s_out;
        logic [SEG_W:0]   w_seg;

        assign w_seg = {1'b0, w_a_in[k][k*SEG_W +: SEG_W]}
                     + {1'b0, w_b_in[k][k*SEG_W +: SEG_W]}
                     + {{SEG_W{1'b0}}, w_c_in[k]};

        always_comb begin
            w_s_out = w_s_in[k];
            w_s_out[k*SEG_W +: SEG_W] = w_seg[SEG_W-1:0];
        end

        assign w_load[k] = !r_valid || w_advance[k];

        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_carry <= 1'b0;
                r_zero  <= 1'b0;
                r_sum   <= '0;
            end else if (w_load[k]) begin
                r_valid <= w_v_in[k];
                if (w_v_in[k]) begin
                    r_carry <= w_seg[SEG_W];
                    r_zero  <= w_z_in[k] && (w_seg[SEG_W-1:0] == '0);
                    r_sum   <= w_s_out;
                end
            end
        end

        if (k < NSEG - 1) begin : g_fwd
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_load[k] && w_v_in[k]) begin
                    r_a <= w_a_in[k];
                    r_b <= w_b_in[k];
                end
            end

            assign w_advance[k]  = r_valid && w_load[k+1];
            assign w_v_in[k+1]   = r_valid;
            assign w_a_in[k+1]   = r_a;
            assign w_b_in[k+1]   = r_b;
            assign w_s_in[k+1]   = r_sum;
            assign w_c_in[k+1]   = r_carry;
            assign w_z_in[k+1]   = r_zero;
        end else begin : g_out
            logic r_ovf;

            // Overflow needs the operand sign bits, which only exist up to this stage.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ovf <= 1'b0;
                end else if (w_load[k] && w_v_in[k]) begin
                    r_ovf <= (w_a_in[k][WIDTH-1] == w_b_in[k][WIDTH-1])
                          && (w_s_out[WIDTH-1] != w_a_in[k][WIDTH-1]);
                end
            end

            assign w_advance[k] = r_valid && out_ready;
            assign out_valid    = r_valid;
            assign sum          = r_sum;
            assign cout         = r_carry;
            assign zero         = r_zero;
            assign neg          = r_sum[WIDTH-1];
            assign ovf          = r_ovf;
        end
    end

endmodule
`default_nettype wire
